// File: rtl/lstm_axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the scratchpad slave.
package lstm_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next word index for an AXI4 burst; the index wraps modulo the power-of-two depth.
module axi4_burst_addr_gen
  import lstm_axi_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 10
) (
  input  logic [IDX_WIDTH-1:0] cur_idx,
  input  logic [1:0]           burst,
  output logic [IDX_WIDTH-1:0] next_idx
);

  // WRAP is stepped like INCR; the reserved encoding is handled the same way.
  always_comb begin
    next_idx = cur_idx;
    case (burst)
      BURST_FIXED:            next_idx = cur_idx;
      BURST_INCR, BURST_WRAP: next_idx = cur_idx + 1'b1;
      default:                next_idx = cur_idx + 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_scratchpad_slave.sv
// AXI4 slave over a simple dual-port word array; independent read and write FSMs.
module axi4_scratchpad_slave
  import lstm_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    sys_clock,
  input  logic                    reset_rtl,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [7:0]              S_AXI_awlen,
  input  logic [2:0]              S_AXI_awsize,
  input  logic [1:0]              S_AXI_awburst,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wlast,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [7:0]              S_AXI_arlen,
  input  logic [2:0]              S_AXI_arsize,
  input  logic [1:0]              S_AXI_arburst,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rlast,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte offset bits never select anything; start addresses are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};

  // ---------------------------------------------------------------- write side
  wr_state_e        w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d, w_idx_nxt;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic [1:0]       w_burst_q, w_burst_d;
  logic             w_err_q, w_err_d;
  logic             w_last_by_cnt;
  logic             mem_we;

  axi4_burst_addr_gen #(
    .IDX_WIDTH (IDX_W)
  ) u_wr_addr_gen (
    .cur_idx  (w_idx_q),
    .burst    (w_burst_q),
    .next_idx (w_idx_nxt)
  );

  always_comb begin
    w_state_d     = w_state_q;
    w_idx_d       = w_idx_q;
    w_len_d       = w_len_q;
    w_cnt_d       = w_cnt_q;
    w_burst_d     = w_burst_q;
    w_err_d       = w_err_q;
    w_last_by_cnt = (w_cnt_q == w_len_q);
    mem_we        = 1'b0;
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    S_AXI_bvalid  = 1'b0;
    S_AXI_bresp   = RESP_OKAY;
    unique case (w_state_q)
      W_IDLE: begin
        S_AXI_awready = 1'b1;
        if (S_AXI_awvalid) begin
          w_idx_d   = S_AXI_awaddr[ADDR_WIDTH-1:2];
          w_len_d   = S_AXI_awlen;
          w_cnt_d   = '0;
          w_burst_d = S_AXI_awburst;
          w_err_d   = (S_AXI_awsize != SIZE_4B);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        S_AXI_wready = 1'b1;
        if (S_AXI_wvalid) begin
          mem_we  = !w_err_q && !reset_rtl;
          w_idx_d = w_idx_nxt;
          w_cnt_d = w_cnt_q + 8'd1;
          // Whichever of wlast or the beat count ends the burst first wins.
          if (S_AXI_wlast || w_last_by_cnt) begin
            w_state_d = W_RESP;
            if (S_AXI_wlast != w_last_by_cnt) w_err_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        S_AXI_bvalid = 1'b1;
        S_AXI_bresp  = resp_of(w_err_q);
        if (S_AXI_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= BURST_INCR;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge sys_clock) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_wstrb[b]) mem[w_idx_q][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_e             r_state_q, r_state_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d, r_idx_nxt;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_err_q, r_err_d;
  logic                  r_err_new;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  axi4_burst_addr_gen #(
    .IDX_WIDTH (IDX_W)
  ) u_rd_addr_gen (
    .cur_idx  (r_idx_q),
    .burst    (r_burst_q),
    .next_idx (r_idx_nxt)
  );

  assign S_AXI_rdata = rdata_q;

  // The data register is loaded one cycle ahead of the beat it presents, so a
  // write landing on the same word in that cycle is not yet visible.
  always_comb begin
    r_state_d     = r_state_q;
    r_idx_d       = r_idx_q;
    r_len_d       = r_len_q;
    r_beat_d      = r_beat_q;
    r_burst_d     = r_burst_q;
    r_err_d       = r_err_q;
    rdata_d       = rdata_q;
    r_err_new     = (S_AXI_arsize != SIZE_4B);
    S_AXI_arready = 1'b0;
    S_AXI_rvalid  = 1'b0;
    S_AXI_rlast   = 1'b0;
    S_AXI_rresp   = RESP_OKAY;
    unique case (r_state_q)
      R_IDLE: begin
        S_AXI_arready = 1'b1;
        if (S_AXI_arvalid) begin
          r_idx_d   = S_AXI_araddr[ADDR_WIDTH-1:2];
          r_len_d   = S_AXI_arlen;
          r_beat_d  = '0;
          r_burst_d = S_AXI_arburst;
          r_err_d   = r_err_new;
          rdata_d   = r_err_new ? '0 : mem[S_AXI_araddr[ADDR_WIDTH-1:2]];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_rvalid = 1'b1;
        S_AXI_rlast  = (r_beat_q == r_len_q);
        S_AXI_rresp  = resp_of(r_err_q);
        if (S_AXI_rready) begin
          if (S_AXI_rlast) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = r_idx_nxt;
            r_beat_d = r_beat_q + 8'd1;
            rdata_d  = r_err_q ? '0 : mem[r_idx_nxt];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= BURST_INCR;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_scratchpad_slave.sv
// Scoreboard bench for axi4_scratchpad_slave: expected beats queued at stimulus, popped on output.
module tb_axi4_scratchpad_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data_q[$];
  logic [31:0] exp_data_q[$];
  logic [1:0]  exp_resp_q[$];
  logic        exp_last_q[$];
  logic [31:0] obs_data_q[$];
  logic [1:0]  obs_resp_q[$];
  logic        obs_last_q[$];

  logic [31:0] e_d, o_d;
  logic [1:0]  e_r, o_r;
  logic        e_l, o_l;

  always #5 clk = ~clk;

  axi4_scratchpad_slave #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32)
  ) dut (
    .sys_clock     (clk),
    .reset_rtl     (rst),
    .S_AXI_awaddr  (awaddr),
    .S_AXI_awlen   (awlen),
    .S_AXI_awsize  (awsize),
    .S_AXI_awburst (awburst),
    .S_AXI_awvalid (awvalid),
    .S_AXI_awready (awready),
    .S_AXI_wdata   (wdata),
    .S_AXI_wstrb   (wstrb),
    .S_AXI_wlast   (wlast),
    .S_AXI_wvalid  (wvalid),
    .S_AXI_wready  (wready),
    .S_AXI_bresp   (bresp),
    .S_AXI_bvalid  (bvalid),
    .S_AXI_bready  (bready),
    .S_AXI_araddr  (araddr),
    .S_AXI_arlen   (arlen),
    .S_AXI_arsize  (arsize),
    .S_AXI_arburst (arburst),
    .S_AXI_arvalid (arvalid),
    .S_AXI_arready (arready),
    .S_AXI_rdata   (rdata),
    .S_AXI_rresp   (rresp),
    .S_AXI_rlast   (rlast),
    .S_AXI_rvalid  (rvalid),
    .S_AXI_rready  (rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_data_q.push_back(d);
    exp_resp_q.push_back(r);
    exp_last_q.push_back(l);
  endtask

  // Data beats are taken from wr_data_q.
  task automatic do_write(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input int nbeats, input logic [3:0] strb,
                          output logic [1:0] resp, output int b_wait, output bit tmo);
    int n;
    tmo = 0;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin step(); n++; end
    if (n >= 50) tmo = 1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wr_data_q.pop_front(); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin step(); n++; end
      if (n >= 50) tmo = 1;
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    b_wait = 0;
    while (!bvalid && b_wait < 50) begin step(); b_wait++; end
    if (b_wait >= 50) tmo = 1;
    resp = bresp;
    step();
    bready = 1'b0;
  endtask

  // Collects beats into obs_*_q; toggle alternates rready starting low.
  task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input int nbeats, input bit toggle,
                         output int first_wait, output int cycles, output int unstable,
                         output bit tmo);
    int          n;
    bit          stall_prev;
    logic [35:0] held;
    obs_data_q.delete(); obs_resp_q.delete(); obs_last_q.delete();
    tmo = 0;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    if (n >= 50) tmo = 1;
    step();
    arvalid = 1'b0;
    rready = !toggle;
    first_wait = -1; cycles = 0; unstable = 0; stall_prev = 0; held = '0;
    while (obs_data_q.size() < nbeats && cycles < 200) begin
      if (stall_prev && ({rdata, rresp, rlast, rvalid} !== held)) unstable++;
      if (rvalid && first_wait < 0) first_wait = cycles;
      if (rvalid && rready) begin
        obs_data_q.push_back(rdata);
        obs_resp_q.push_back(rresp);
        obs_last_q.push_back(rlast);
      end
      stall_prev = rvalid && !rready;
      held = {rdata, rresp, rlast, rvalid};
      step();
      cycles++;
      if (toggle) rready = !rready;
    end
    if (obs_data_q.size() < nbeats) tmo = 1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; awlen = 0; awsize = 3'b010; awburst = 2'b01; wdata = 0; wstrb = 0;
    araddr = 0; arlen = 0; arsize = 3'b010; arburst = 2'b01;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got awready=%b arready=%b, expected 1 1", awready, arready);
    end
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_wchan: got wready=%b bvalid=%b bresp=%b, expected 0 0 00",
               wready, bvalid, bresp);
    end
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rchan: got rvalid=%b rlast=%b rresp=%b rdata=%h, expected all 0",
               rvalid, rlast, rresp, rdata);
    end
  endtask

  task automatic test_single();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    wr_data_q.push_back(32'hDEADBEEF);
    do_write(12'h100, 8'd0, 2'b01, 3'b010, 1, 4'hF, resp, bw, tmo);
    checks++;
    if (tmo || resp !== 2'b00 || bw != 0) begin
      errors++;
      $display("FAIL single_bresp: got bresp=%b wait=%0d tmo=%0d, expected 00 0 0", resp, bw, tmo);
    end
    push_exp(32'hDEADBEEF, 2'b00, 1'b1);
    do_read(12'h100, 8'd0, 2'b01, 3'b010, 1, 1'b0, fw, cyc, unst, tmo);
    checks++;
    if (tmo || fw != 0) begin
      errors++;
      $display("FAIL single_rlatency: got first rvalid after %0d cycles tmo=%0d, expected 0", fw, tmo);
    end
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL single_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL single_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_incr_stall();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    for (int i = 1; i <= 4; i++) wr_data_q.push_back(32'(i));
    do_write(12'h200, 8'd3, 2'b01, 3'b010, 4, 4'hF, resp, bw, tmo);
    checks++;
    if (tmo || resp !== 2'b00) begin
      errors++;
      $display("FAIL incr_bresp: got bresp=%b tmo=%0d, expected 00 0", resp, tmo);
    end
    for (int i = 1; i <= 4; i++) push_exp(32'(i), 2'b00, i == 4);
    do_read(12'h200, 8'd3, 2'b01, 3'b010, 4, 1'b1, fw, cyc, unst, tmo);
    checks++;
    if (tmo || unst != 0) begin
      errors++;
      $display("FAIL incr_stall_stable: got %0d changes while stalled tmo=%0d, expected 0", unst, tmo);
    end
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL incr_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL incr_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    wr_data_q.push_back(32'h11223344);
    do_write(12'h010, 8'd0, 2'b01, 3'b010, 1, 4'hF, resp, bw, tmo);
    wr_data_q.push_back(32'hAAAABBBB);
    do_write(12'h010, 8'd0, 2'b01, 3'b010, 1, 4'b0011, resp, bw, tmo);
    push_exp(32'h1122BBBB, 2'b00, 1'b1);
    do_read(12'h010, 8'd0, 2'b01, 3'b010, 1, 1'b0, fw, cyc, unst, tmo);
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL strobe_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_fixed_wrap();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    wr_data_q.push_back(32'h5);
    wr_data_q.push_back(32'h6);
    do_write(12'h020, 8'd1, 2'b00, 3'b010, 2, 4'hF, resp, bw, tmo);
    wr_data_q.push_back(32'hA1A1A1A1);
    wr_data_q.push_back(32'hB2B2B2B2);
    do_write(12'hFFC, 8'd1, 2'b01, 3'b010, 2, 4'hF, resp, bw, tmo);
    push_exp(32'h6, 2'b00, 1'b1);
    do_read(12'h020, 8'd0, 2'b01, 3'b010, 1, 1'b0, fw, cyc, unst, tmo);
    push_exp(32'hA1A1A1A1, 2'b00, 1'b0);
    push_exp(32'hB2B2B2B2, 2'b00, 1'b1);
    // Observed queue is refilled by the second read; keep the first beat.
    e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
    checks++;
    if (obs_data_q.size() == 0) begin
      errors++;
      $display("FAIL fixed_read: got no beat, expected data=%h", e_d);
    end else begin
      o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
      if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
        errors++;
        $display("FAIL fixed_read: got %h/%b/%b, expected %h/%b/%b", o_d, o_r, o_l, e_d, e_r, e_l);
      end
    end
    do_read(12'hFFC, 8'd1, 2'b01, 3'b010, 2, 1'b0, fw, cyc, unst, tmo);
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL wrap_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_size_error();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    wr_data_q.push_back(32'hCAFEF00D);
    do_write(12'h300, 8'd0, 2'b01, 3'b010, 1, 4'hF, resp, bw, tmo);
    wr_data_q.push_back(32'h12345678);
    do_write(12'h300, 8'd0, 2'b01, 3'b001, 1, 4'hF, resp, bw, tmo);
    checks++;
    if (tmo || resp !== 2'b10) begin
      errors++;
      $display("FAIL size_err_bresp: got bresp=%b tmo=%0d, expected 10 0", resp, tmo);
    end
    push_exp(32'hCAFEF00D, 2'b00, 1'b1);
    do_read(12'h300, 8'd0, 2'b01, 3'b010, 1, 1'b0, fw, cyc, unst, tmo);
    e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
    checks++;
    if (obs_data_q.size() == 0) begin
      errors++;
      $display("FAIL size_err_unchanged: got no beat, expected data=%h", e_d);
    end else begin
      o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
      if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
        errors++;
        $display("FAIL size_err_unchanged: got %h/%b/%b, expected %h/%b/%b",
                 o_d, o_r, o_l, e_d, e_r, e_l);
      end
    end
    for (int i = 0; i < 3; i++) push_exp(32'h0, 2'b10, i == 2);
    do_read(12'h300, 8'd2, 2'b01, 3'b001, 3, 1'b0, fw, cyc, unst, tmo);
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL size_err_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL size_err_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    int bw, fw, cyc, unst;
    bit tmo;
    for (int i = 0; i < 8; i++) wr_data_q.push_back(32'h4000_0000 + 32'(i * 3));
    do_write(12'h400, 8'd7, 2'b01, 3'b010, 8, 4'hF, resp, bw, tmo);
    for (int i = 0; i < 8; i++) push_exp(32'h4000_0000 + 32'(i * 3), 2'b00, i == 7);
    do_read(12'h400, 8'd7, 2'b01, 3'b010, 8, 1'b0, fw, cyc, unst, tmo);
    checks++;
    if (tmo || fw != 0 || cyc != 8) begin
      errors++;
      $display("FAIL b2b_throughput: got first=%0d cycles=%0d tmo=%0d, expected 0 8 0", fw, cyc, tmo);
    end
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL b2b_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    int n, fw, cyc, unst;
    bit tmo;
    araddr = 12'h200; arlen = 8'd7; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0;
    rready = 1'b1;
    step();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h2) begin
      errors++;
      $display("FAIL midburst_beat2: got rvalid=%b rdata=%h, expected 1 00000002", rvalid, rdata);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || arready !== 1'b1 ||
        awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: got rvalid=%b rlast=%b rdata=%h arready=%b awready=%b bvalid=%b, expected 0 0 0 1 1 0",
               rvalid, rlast, rdata, arready, awready, bvalid);
    end
    push_exp(32'hDEADBEEF, 2'b00, 1'b1);
    do_read(12'h100, 8'd0, 2'b01, 3'b010, 1, 1'b0, fw, cyc, unst, tmo);
    for (int i = 0; exp_data_q.size() > 0; i++) begin
      e_d = exp_data_q.pop_front(); e_r = exp_resp_q.pop_front(); e_l = exp_last_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0) begin
        errors++;
        $display("FAIL post_reset_read beat %0d: got no beat, expected data=%h", i, e_d);
      end else begin
        o_d = obs_data_q.pop_front(); o_r = obs_resp_q.pop_front(); o_l = obs_last_q.pop_front();
        if (o_d !== e_d || o_r !== e_r || o_l !== e_l) begin
          errors++;
          $display("FAIL post_reset_read beat %0d: got %h/%b/%b, expected %h/%b/%b",
                   i, o_d, o_r, o_l, e_d, e_r, e_l);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_stall();
    test_strobe();
    test_fixed_wrap();
    test_size_error();
    test_back_to_back();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
